ps2_tx: RTL and testbench

//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED LED set,
//  0xF4 enable) from the FPGA to the keyboard over the shared ps2c/ps2d lines.

---
 rtl/ps2_tx.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_tx.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_tx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_tx
// Description : Host-to-device PS/2 transmitter. Sends one command byte
//               (e.g. 0xED LED set, 0xF4 enable) to the keyboard over the
//               shared open-drain ps2c/ps2d lines. Sits beside the receive
//               path; the receiver should only be enabled while tx_idle=1.
// Optional    : define PS2_TX_ACK_EN to add the device-acknowledge slot and
//               the ack_err output.
// Ports       : clk          - system clock
//               reset        - asynchronous, active-high reset
//               wr_ps2       - start request, din captured on acceptance
//               din[7:0]     - command byte
//               ps2c, ps2d   - PS/2 clock/data, driven low or released only
//               tx_idle      - 1 = idle, a request will be accepted
//               tx_done_tick - one-cycle pulse when the frame completes
//               ack_err      - (PS2_TX_ACK_EN) 1 = device did not acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_tx #(
    parameter int RTS_CNT    = 8191,
    parameter int FILTER_LEN = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick
`ifdef PS2_TX_ACK_EN
    ,
    output logic       ack_err
`endif
);

    localparam int CNT_W = (RTS_CNT > 1) ? $clog2(RTS_CNT) : 1;

`ifdef PS2_TX_ACK_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4,
        S_ACK   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RTS   = 3'd1,
        S_START = 3'd2,
        S_DATA  = 3'd3,
        S_STOP  = 3'd4
    } state_t;
`endif

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [3:0]         n_q;
    logic [8:0]         b_q;         // {parity, data}, LSB goes out first
    logic               c_low_q;     // 1 = pull ps2c low
    logic               d_low_q;     // 1 = pull ps2d low
    logic               tx_idle_q;
    logic               done_q;
`ifdef PS2_TX_ACK_EN
    logic               ack_err_q;
`endif

    // ------------------------------------------------------------------
    // ps2c glitch filter: the filtered clock only changes once the last
    // FILTER_LEN raw samples agree, so short spikes never produce a fall.
    // ------------------------------------------------------------------
    logic [FILTER_LEN-1:0] filt_q;
    logic [FILTER_LEN-1:0] filt_d;
    logic                  fclk_q;
    logic                  fclk_d;
    logic                  fall;

    always_comb begin
        filt_d = {filt_q[FILTER_LEN-2:0], ps2c};
        fclk_d = fclk_q;
        if (&filt_d) begin
            fclk_d = 1'b1;
        end else if (~|filt_d) begin
            fclk_d = 1'b0;
        end
        fall = fclk_q & ~fclk_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= '0;
            fclk_q <= 1'b0;
        end else begin
            filt_q <= filt_d;
            fclk_q <= fclk_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer. Line drives and status flags are registered and
    // updated together with the state they belong to.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            n_q       <= '0;
            b_q       <= '0;
            c_low_q   <= 1'b0;
            d_low_q   <= 1'b0;
            tx_idle_q <= 1'b1;
            done_q    <= 1'b0;
`ifdef PS2_TX_ACK_EN
            ack_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (wr_ps2) begin
                        b_q       <= {~^din, din};
                        cnt_q     <= CNT_W'(RTS_CNT - 1);
                        c_low_q   <= 1'b1;
                        tx_idle_q <= 1'b0;
                        state_q   <= S_RTS;
`ifdef PS2_TX_ACK_EN
                        ack_err_q <= 1'b0;
`endif
                    end
                end
                S_RTS: begin
                    // Our own low pulse is ignored here: no fall is consumed.
                    if (cnt_q == '0) begin
                        c_low_q <= 1'b0;
                        d_low_q <= 1'b1;        // start bit
                        state_q <= S_START;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_START: begin
                    if (fall) begin
                        d_low_q <= ~b_q[0];
                        n_q     <= 4'd8;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    // Eight falls shift out data bits 1..7 and the parity
                    // bit; the ninth fall ends the data phase.
                    if (fall) begin
                        if (n_q == 4'd0) begin
                            d_low_q <= 1'b0;    // stop bit = released
                            state_q <= S_STOP;
                        end else begin
                            b_q     <= b_q >> 1;
                            n_q     <= n_q - 1'b1;
                            d_low_q <= ~b_q[1];
                        end
                    end
                end
                S_STOP: begin
                    if (fall) begin
`ifdef PS2_TX_ACK_EN
                        state_q   <= S_ACK;
`else
                        done_q    <= 1'b1;
                        tx_idle_q <= 1'b1;
                        state_q   <= S_IDLE;
`endif
                    end
                end
`ifdef PS2_TX_ACK_EN
                S_ACK: begin
                    if (fall) begin
                        ack_err_q <= (ps2d == 1'b0) ? 1'b0 : 1'b1;
                        done_q    <= 1'b1;
                        tx_idle_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
`endif
                default: begin
                    c_low_q   <= 1'b0;
                    d_low_q   <= 1'b0;
                    tx_idle_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
            endcase
        end
    end

    // Open-drain: lines are pulled low or left floating, never driven high.
    assign ps2c         = c_low_q ? 1'b0 : 1'bz;
    assign ps2d         = d_low_q ? 1'b0 : 1'bz;
    assign tx_idle      = tx_idle_q;
    assign tx_done_tick = done_q;
`ifdef PS2_TX_ACK_EN
    assign ack_err      = ack_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ps2_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_tx
// Description : Testbench for ps2_tx. A keyboard model clocks the frame out
//               of the transmitter and the observed bits are compared with
//               the frame computed from the byte (start, LSB-first data, odd
//               parity, stop).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_tx;

    localparam int RTS = 40;
    localparam int FLT = 8;
    localparam int H   = 25;        // device clock half period in clk cycles
`ifdef PS2_TX_ACK_EN
    localparam int NFALL = 12;
`else
    localparam int NFALL = 11;
`endif

    logic       clk;
    logic       reset;
    logic       wr_ps2;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
`ifdef PS2_TX_ACK_EN
    logic       ack_err;
    logic       ack_at_done;
`endif

    logic       dev_c_low;
    logic       dev_d_low;

    int tests;
    int fails;
    int done_cnt;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    ps2_tx #(
        .RTS_CNT    (RTS),
        .FILTER_LEN (FLT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_ps2       (wr_ps2),
        .din          (din),
        .ps2c         (ps2c),
        .ps2d         (ps2d),
        .tx_idle      (tx_idle),
        .tx_done_tick (tx_done_tick)
`ifdef PS2_TX_ACK_EN
        ,
        .ack_err      (ack_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) begin
            done_cnt++;
`ifdef PS2_TX_ACK_EN
            ack_at_done = ack_err;
`endif
        end
    end

    // Reference frame: index 0 = start, 1..8 = data LSB first, 9 = parity,
    // 10 = stop. Parity makes the total count of ones in data+parity odd.
    function automatic logic [10:0] frame_model(input logic [7:0] d);
        int          ones;
        logic [10:0] f;
        ones = 0;
        f    = '0;
        for (int j = 0; j < 8; j++) begin
            if (d[j]) ones++;
            f[1+j] = d[j];
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (tx_idle !== 1'b1) begin
            fails++; $display("FAIL reset_idle: got %b expected 1", tx_idle);
        end
        tests++;
        if (tx_done_tick !== 1'b0) begin
            fails++; $display("FAIL reset_done: got %b expected 0", tx_done_tick);
        end
        tests++;
        if (ps2c !== 1'b1 || ps2d !== 1'b1) begin
            fails++; $display("FAIL reset_lines: got c=%b d=%b expected released", ps2c, ps2d);
        end
`ifdef PS2_TX_ACK_EN
        tests++;
        if (ack_err !== 1'b0) begin
            fails++; $display("FAIL reset_ack_err: got %b expected 0", ack_err);
        end
`endif
        reset = 1'b0;
        repeat (FLT + 4) @(negedge clk);
    endtask

    // mode 0: plain frame, 1: extra wr_ps2 with din=0 during DATA,
    // 2: one-cycle ps2c glitch during DATA, 3: reset asserted mid-DATA.
    task automatic test_frame(input string name, input logic [7:0] d,
                              input int mode, input bit ack_low);
        logic [10:0] exp;
        logic [11:0] obs;
        int          base;
        int          rts;
        exp  = frame_model(d);
        obs  = '0;
        base = done_cnt;

        @(negedge clk);
        tests++;
        if (tx_idle !== 1'b1) begin
            fails++; $display("FAIL %s idle_before: got %b expected 1", name, tx_idle);
        end
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = 8'($urandom);
        tests++;
        if (tx_idle !== 1'b0) begin
            fails++; $display("FAIL %s idle_busy: got %b expected 0", name, tx_idle);
        end

        rts = 0;
        while (ps2c === 1'b0 && rts < RTS + 100) begin
            rts++;
            @(negedge clk);
        end
        tests++;
        if (rts != RTS) begin
            fails++; $display("FAIL %s rts_len: got %0d cycles expected %0d", name, rts, RTS);
        end

        repeat (10) @(negedge clk);
        for (int i = 0; i < NFALL; i++) begin
            if (mode == 1 && i == 4) begin
                din    = 8'h00;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
                din    = 8'($urandom);
            end
            if (mode == 2 && i == 5) begin
                dev_c_low = 1'b1;
                @(negedge clk);
                dev_c_low = 1'b0;
                repeat (3) @(negedge clk);
            end
            if (mode == 3 && i == 5) begin
                reset = 1'b1;
                #1;
                tests++;
                if (ps2c !== 1'b1 || ps2d !== 1'b1) begin
                    fails++; $display("FAIL %s reset_lines: got c=%b d=%b expected released", name, ps2c, ps2d);
                end
                tests++;
                if (tx_idle !== 1'b1) begin
                    fails++; $display("FAIL %s reset_idle: got %b expected 1", name, tx_idle);
                end
                @(negedge clk);
                reset = 1'b0;
                repeat (60) @(negedge clk);
                tests++;
                if (done_cnt - base != 0) begin
                    fails++; $display("FAIL %s reset_no_done: got %0d ticks expected 0", name, done_cnt - base);
                end
                tests++;
                if (tx_idle !== 1'b1) begin
                    fails++; $display("FAIL %s reset_idle_after: got %b expected 1", name, tx_idle);
                end
                return;
            end
            if (i == 11) dev_d_low = ack_low;
            @(negedge clk);
            obs[i] = ps2d;
            dev_c_low = 1'b1;
            repeat (H) @(negedge clk);
            dev_c_low = 1'b0;
            dev_d_low = 1'b0;
            repeat (H) @(negedge clk);
        end
        repeat (20) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            tests++;
            if (obs[i] !== exp[i]) begin
                fails++; $display("FAIL %s bit%0d: got %b expected %b (din=%02h)", name, i, obs[i], exp[i], d);
            end
        end
        tests++;
        if (done_cnt - base != 1) begin
            fails++; $display("FAIL %s done_ticks: got %0d expected 1", name, done_cnt - base);
        end
        tests++;
        if (tx_idle !== 1'b1) begin
            fails++; $display("FAIL %s idle_after: got %b expected 1", name, tx_idle);
        end
`ifdef PS2_TX_ACK_EN
        tests++;
        if (ack_at_done !== ~ack_low) begin
            fails++; $display("FAIL %s ack_err: got %b expected %b", name, ack_at_done, ~ack_low);
        end
        tests++;
        if (ack_err !== ~ack_low) begin
            fails++; $display("FAIL %s ack_err_hold: got %b expected %b", name, ack_err, ~ack_low);
        end
`endif
    endtask

    task automatic test_random();
        logic [7:0] d;
        bit         a;
        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            a = 1'($urandom);
            test_frame("random", d, 0, a);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        done_cnt  = 0;
        reset     = 1'b1;
        wr_ps2    = 1'b0;
        din       = 8'h00;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
`ifdef PS2_TX_ACK_EN
        ack_at_done = 1'b0;
`endif
        test_reset();
        test_frame("led_cmd_ED", 8'hED, 0, 1'b1);
        test_frame("enable_F4", 8'hF4, 0, 1'b1);
        test_frame("ignore_wr", 8'hA5, 1, 1'b1);
        test_frame("glitch", 8'h3C, 2, 1'b1);
        test_frame("reset_mid_data", 8'h81, 3, 1'b1);
        test_frame("after_reset", 8'h00, 0, 1'b1);
`ifdef PS2_TX_ACK_EN
        test_frame("no_ack", 8'hED, 0, 1'b0);
        test_frame("ack_ok", 8'hF4, 0, 1'b1);
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
